phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 55 +++++
 rtl/branch_cond.sv | 36 +++
 rtl/phase_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_phase_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer_pkg
// Description : Shared definitions for the phase sequencer.
//               - phase (state) codes
//               - instruction class codes and ALU op codes
//               - branch condition codes and flag bit positions
// Revision    : 1.0 - initial release
// ============================================================================
package phase_sequencer_pkg;

    // Phase / state codes, also driven directly onto the phase output
    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_P1   = 3'd1;
    localparam logic [2:0] PH_P2   = 3'd2;
    localparam logic [2:0] PH_P3   = 3'd3;
    localparam logic [2:0] PH_P4   = 3'd4;
    localparam logic [2:0] PH_P5   = 3'd5;
    localparam logic [2:0] PH_HALT = 3'd6;
    localparam logic [2:0] PH_ERR  = 3'd7;

    // Instruction class, taken from ir[15:14]
    typedef enum logic [1:0] {
        CLS_LD  = 2'b00,
        CLS_ST  = 2'b01,
        CLS_BR  = 2'b10,
        CLS_ALU = 2'b11
    } instr_class_t;

    // ALU op codes with special sequencing, taken from ir[7:4]
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Branch condition codes, taken from ir[10:8]; 110/111 never branch
    localparam logic [2:0] BC_ALWAYS = 3'b000;
    localparam logic [2:0] BC_EQ     = 3'b001;
    localparam logic [2:0] BC_LT     = 3'b010;
    localparam logic [2:0] BC_LE     = 3'b011;
    localparam logic [2:0] BC_NE     = 3'b100;
    localparam logic [2:0] BC_CS     = 3'b101;

    // Flag bit positions within flags = {V,C,Z,S}
    localparam int FLAG_S = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Load and store both need a data-memory phase
    function automatic logic is_mem_class(input instr_class_t cls);
        return (cls == CLS_LD) || (cls == CLS_ST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational branch condition evaluator.
// Ports       : cond  [2:0] in  - condition code from the instruction
//               flags [3:0] in  - latched ALU flags {V,C,Z,S}
//               taken       out - 1 when the branch is to be taken
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import phase_sequencer_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    // Signed less-than: sign differs from overflow
    logic lt;
    assign lt = flags[FLAG_S] ^ flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            BC_ALWAYS: taken = 1'b1;
            BC_EQ:     taken = flags[FLAG_Z];
            BC_LT:     taken = lt;
            BC_LE:     taken = flags[FLAG_Z] | lt;
            BC_NE:     taken = ~flags[FLAG_Z];
            BC_CS:     taken = flags[FLAG_C];
            default:   taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Five-phase instruction sequencer (fetch, read, execute,
//               memory, writeback) with bounded memory waits, sticky HALT
//               and ERR states.
// Config      : PHASE_SKIP_EN - when defined, non-LD/ST instructions skip P4
//               and go P3 -> P5.
// Parameters  : WAIT_LIMIT (1..255) - max cycles a memory request waits.
// Ports       : clock, reset_n (async, active low)
//               run       in  - leave IDLE / continue after P5
//               ir[15:0]  in  - instruction, valid from P2 onward
//               flags[3:0]in  - latched ALU flags {V,C,Z,S}
//               mem_ack   in  - memory completion
//               phase[2:0]out - current state code
//               mem_req, mem_we               out - memory request
//               ir_load, pc_inc, pc_load, rf_read, alu_en, flag_we,
//               rf_we, out_en                 out - one-cycle strobes
//               halted, error                 out - sticky status
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    input  logic        mem_ack,
    output logic [2:0]  phase,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        rf_read,
    output logic        alu_en,
    output logic        flag_we,
    output logic        rf_we,
    output logic        out_en,
    output logic        halted,
    output logic        error
);

`ifdef PHASE_SKIP_EN
    localparam logic SKIP_P4 = 1'b1;
`else
    localparam logic SKIP_P4 = 1'b0;
`endif

    // Last count value tolerated before the wait is declared failed
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] wait_cnt;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    instr_class_t cls;
    logic [3:0]   op;
    logic         is_mem;
    logic         is_alu;
    logic         op_halt;
    logic         op_out;
    logic         op_cmp;
    logic         br_taken;
    logic         ir_unused;

    assign cls     = instr_class_t'(ir[15:14]);
    assign op      = ir[7:4];
    assign is_mem  = is_mem_class(cls);
    assign is_alu  = (cls == CLS_ALU);
    assign op_halt = is_alu && (op == OP_HALT);
    assign op_out  = is_alu && (op == OP_OUT);
    assign op_cmp  = is_alu && (op == OP_CMP);

    // Register-select and immediate fields belong to the datapath
    assign ir_unused = ^{ir[13:11], ir[3:0]};

    branch_cond u_branch_cond (
        .cond  (ir[10:8]),
        .flags (flags),
        .taken (br_taken)
    );

    // ------------------------------------------------------------------
    // Memory wait tracking
    // ------------------------------------------------------------------
    // P1 always waits on the instruction fetch; P4 waits only for LD/ST.
    logic in_wait;
    logic wait_expired;

    assign in_wait      = (state == PH_P1) || ((state == PH_P4) && is_mem);
    // An ack on the final allowed cycle still completes the access.
    assign wait_expired = in_wait && !mem_ack && (wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            PH_IDLE: if (run) state_next = PH_P1;
            PH_P1: begin
                if (mem_ack)           state_next = PH_P2;
                else if (wait_expired) state_next = PH_ERR;
            end
            PH_P2: state_next = PH_P3;
            PH_P3: begin
                if (op_halt)                 state_next = PH_HALT;
                else if (SKIP_P4 && !is_mem) state_next = PH_P5;
                else                         state_next = PH_P4;
            end
            PH_P4: begin
                if (!is_mem)           state_next = PH_P5;
                else if (mem_ack)      state_next = PH_P5;
                else if (wait_expired) state_next = PH_ERR;
            end
            PH_P5:   state_next = run ? PH_P1 : PH_IDLE;
            PH_HALT: state_next = PH_HALT;
            PH_ERR:  state_next = PH_ERR;
            default: state_next = PH_ERR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= PH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The counter restarts on every phase change, so each wait phase
    // begins at zero regardless of how it was entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (state_next != state) begin
            wait_cnt <= 8'd0;
        end else if (in_wait && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so that an asynchronous reset clears
    // them in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        rf_read = 1'b0;
        alu_en  = 1'b0;
        flag_we = 1'b0;
        rf_we   = 1'b0;
        out_en  = 1'b0;
        halted  = 1'b0;
        error   = 1'b0;
        case (state)
            PH_P1: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                pc_inc  = mem_ack;
            end
            PH_P2: rf_read = 1'b1;
            PH_P3: begin
                if (is_alu && !op_halt) begin
                    alu_en  = 1'b1;
                    flag_we = !op_out;
                end else if (is_mem) begin
                    alu_en  = 1'b1;
                end else if (cls == CLS_BR) begin
                    pc_load = br_taken;
                end
            end
            PH_P4: begin
                mem_req = is_mem;
                mem_we  = (cls == CLS_ST);
            end
            PH_P5: begin
                rf_we  = (cls == CLS_LD) || (is_alu && !op_cmp && !op_out);
                out_en = op_out;
            end
            PH_HALT: halted = 1'b1;
            PH_ERR: begin
                halted = 1'b1;
                error  = 1'b1;
            end
            default: ;
        endcase
    end

    assign phase = state;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Self-checking bench for phase_sequencer. Each instruction's
//               expected cycle trace is generated from the sequencing rules
//               and compared every cycle against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

    typedef struct packed {
        logic [2:0] ph;
        logic mreq, mwe, irl, pci, pcl, rfr, alu, fwe, rfw, oen, hlt, err;
    } exp_t;

`ifdef PHASE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] ir = 16'h0;
    logic [3:0]  flags = 4'h0;
    logic        mem_ack = 1'b0;
    logic [2:0]  phase;
    logic mem_req, mem_we, ir_load, pc_inc, pc_load, rf_read, alu_en;
    logic flag_we, rf_we, out_en, halted, error;

    logic        reset2_n = 1'b0;
    logic        run2 = 1'b0;
    logic        mem_ack2 = 1'b0;
    logic [2:0]  phase_b;
    logic mem_req_b, mem_we_b, ir_load_b, pc_inc_b, pc_load_b, rf_read_b;
    logic alu_en_b, flag_we_b, rf_we_b, out_en_b, halted_b, error_b;

    int checks = 0;
    int failures = 0;
    bit at_idle = 1'b1;

    always #5 clock = ~clock;

    phase_sequencer dut (
        .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .flags(flags),
        .mem_ack(mem_ack), .phase(phase), .mem_req(mem_req), .mem_we(mem_we),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .rf_read(rf_read), .alu_en(alu_en), .flag_we(flag_we), .rf_we(rf_we),
        .out_en(out_en), .halted(halted), .error(error)
    );

    phase_sequencer #(.WAIT_LIMIT(2)) dut_short (
        .clock(clock), .reset_n(reset2_n), .run(run2), .ir(ir), .flags(flags),
        .mem_ack(mem_ack2), .phase(phase_b), .mem_req(mem_req_b),
        .mem_we(mem_we_b), .ir_load(ir_load_b), .pc_inc(pc_inc_b),
        .pc_load(pc_load_b), .rf_read(rf_read_b), .alu_en(alu_en_b),
        .flag_we(flag_we_b), .rf_we(rf_we_b), .out_en(out_en_b),
        .halted(halted_b), .error(error_b)
    );

    exp_t obs, obs_b;
    assign obs   = {phase, mem_req, mem_we, ir_load, pc_inc, pc_load, rf_read,
                    alu_en, flag_we, rf_we, out_en, halted, error};
    assign obs_b = {phase_b, mem_req_b, mem_we_b, ir_load_b, pc_inc_b,
                    pc_load_b, rf_read_b, alu_en_b, flag_we_b, rf_we_b,
                    out_en_b, halted_b, error_b};

    function automatic exp_t mk(input logic [2:0] p);
        exp_t e;
        e = '0;
        e.ph = p;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom & 1);
    endfunction

    // Branch rule table written from the condition definitions
    function automatic logic ref_taken(input logic [2:0] c, input logic [3:0] f);
        logic s, z, cy, v;
        {v, cy, z, s} = f;
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return s != v;
            3'd3:    return z || (s != v);
            3'd4:    return !z;
            3'd5:    return cy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input exp_t got, input exp_t want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (phase %0d vs %0d)",
                   tag, got, want, got.ph, want.ph);
        end
    endtask

    task automatic drive_check(input exp_t e, input logic ack, input logic r,
                               input logic [15:0] iv, input logic [3:0] fl,
                               input string tag);
        @(negedge clock);
        mem_ack = ack;
        run     = r;
        ir      = iv;
        flags   = fl;
        #1;
        check(tag, obs, e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        mem_ack = 1'b0;
        @(negedge clock);
        #1;
        check("reset", obs, mk(3'd0));
        @(negedge clock);
        reset_n = 1'b1;
        at_idle = 1'b1;
    endtask

    // d1/d4: cycles of ack withheld in P1/P4. abort_p4 >= 0 asserts
    // reset during that P4 wait cycle instead of completing.
    task automatic do_instr(input logic [15:0] iv, input logic [3:0] fl,
                            input int d1, input int d4, input logic run_next,
                            input int abort_p4);
        logic [1:0] cls;
        logic [3:0] op;
        bit mem, alu, halt_op;
        exp_t e;
        cls = iv[15:14];
        op  = iv[7:4];
        mem = (cls == 2'b00) || (cls == 2'b01);
        alu = (cls == 2'b11);
        halt_op = alu && (op == 4'hF);

        if (at_idle) drive_check(mk(3'd0), rb(), 1'b1, 16'($urandom), 4'($urandom), "idle");

        for (int i = 0; i <= d1; i++) begin
            e = mk(3'd1);
            e.mreq = 1'b1;
            e.irl  = (i == d1);
            e.pci  = (i == d1);
            drive_check(e, (i == d1), rb(), 16'($urandom), 4'($urandom), "p1_fetch");
        end

        e = mk(3'd2);
        e.rfr = 1'b1;
        drive_check(e, rb(), rb(), iv, 4'($urandom), "p2_read");

        e = mk(3'd3);
        if (alu && !halt_op) begin
            e.alu = 1'b1;
            e.fwe = (op != 4'hD);
        end else if (mem) begin
            e.alu = 1'b1;
        end else if (cls == 2'b10) begin
            e.pcl = ref_taken(iv[10:8], fl);
        end
        drive_check(e, rb(), rb(), iv, fl, "p3_exec");

        if (halt_op) begin
            for (int i = 0; i < 4; i++) begin
                e = mk(3'd6);
                e.hlt = 1'b1;
                drive_check(e, rb(), 1'b1, iv, 4'($urandom), "halt_sticky");
            end
            at_idle = 1'b0;
            return;
        end

        if (mem) begin
            for (int i = 0; i <= d4; i++) begin
                e = mk(3'd4);
                e.mreq = 1'b1;
                e.mwe  = (cls == 2'b01);
                drive_check(e, (i == d4), rb(), iv, 4'($urandom), "p4_mem");
                if (i == abort_p4) begin
                    #1 reset_n = 1'b0;
                    run = 1'b0;
                    #1 check("reset_async", obs, mk(3'd0));
                    @(negedge clock);
                    reset_n = 1'b1;
                    #1 check("reset_release", obs, mk(3'd0));
                    at_idle = 1'b1;
                    return;
                end
            end
        end else if (!SKIP) begin
            drive_check(mk(3'd4), rb(), rb(), iv, 4'($urandom), "p4_idle");
        end

        e = mk(3'd5);
        e.rfw = (cls == 2'b00) || (alu && op != 4'h5 && op != 4'hD);
        e.oen = alu && (op == 4'hD);
        drive_check(e, rb(), run_next, iv, 4'($urandom), "p5_write");
        at_idle = !run_next;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] iv;
        exp_t e;

        do_reset();

        // CMP, fetch ack one cycle after request
        do_instr(16'hC050, 4'h0, 1, 0, 1'b1, -1);
        // Branch on Z, taken then not taken
        do_instr(16'h8100, 4'b0010, 0, 0, 1'b1, -1);
        do_instr(16'h8100, 4'b0000, 0, 0, 1'b0, -1);
        // LD with ack withheld 3 cycles in P4
        do_instr(16'h0000, 4'h0, 0, 3, 1'b1, -1);
        // ADD (skips P4 when configured), ST, OUT
        do_instr(16'hC000, 4'h0, 2, 0, 1'b1, -1);
        do_instr(16'h4000, 4'h0, 0, 2, 1'b1, -1);
        do_instr(16'hC0D0, 4'h0, 0, 0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            iv = 16'($urandom);
            if (iv[15:14] == 2'b11 && iv[7:4] == 4'hF) iv[7:4] = 4'h0;
            do_instr(iv, 4'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 4), ($urandom_range(0, 3) != 0), -1);
        end

        // HALT is sticky until reset
        do_instr(16'hC0F0, 4'h0, 0, 0, 1'b1, -1);
        do_reset();

        // Reset during a P4 wait, then a clean instruction afterwards
        do_instr(16'h0000, 4'h0, 0, 5, 1'b1, 1);
        do_instr(16'hC010, 4'h0, 0, 0, 1'b0, -1);

        // Short wait limit: fetch never acked -> ERR after 2 request cycles
        @(negedge clock);
        reset2_n = 1'b1;
        run2     = 1'b1;
        mem_ack2 = 1'b0;
        #1 check("short_idle", obs_b, mk(3'd0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            e = mk(3'd1);
            e.mreq = 1'b1;
            check("short_wait", obs_b, e);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            mem_ack2 = 1'b1;
            #1;
            e = mk(3'd7);
            e.hlt = 1'b1;
            e.err = 1'b1;
            check("short_err", obs_b, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
